// File: rtl/fas_unpack_stage.sv
// Operand unpack/order stage at the head of the FP add/sub pipeline.
// Optional FAS_SKID_EN adds a skid entry so in_ready is a registered output.
module fas_unpack_stage #(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MAN_W   = 23,
    parameter int unsigned GUARD_W = 8,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic                                   in_sub,
    input  logic [EXP_W+MAN_W:0]                   in_a,
    input  logic [EXP_W+MAN_W:0]                   in_b,
    input  logic [TAG_W-1:0]                       in_tag,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [EXP_W+GUARD_W+MAN_W+2:0]         out_x,
    output logic [EXP_W+GUARD_W+MAN_W+2:0]         out_y,
    output logic [EXP_W:0]                         out_diff,
    output logic                                   out_nan,
    output logic                                   out_inf,
    output logic                                   out_inf_s,
    output logic [TAG_W-1:0]                       out_tag
);

    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned SIG_W  = GUARD_W + 1 + MAN_W;
    localparam int unsigned DIFF_W = EXP_W + 1;
    localparam int unsigned UNP_W  = 1 + DIFF_W + SIG_W;
    localparam int unsigned PAY_W  = 2 * UNP_W + DIFF_W + 3 + TAG_W;

    // Zero/denormal flush to all-zero; everything else gets the hidden bit.
    function automatic logic [UNP_W-1:0] unpack(input logic s,
                                                 input logic [EXP_W-1:0] e,
                                                 input logic [MAN_W-1:0] m);
        logic [UNP_W-1:0] r;
        r = '0;
        if (e != '0) begin
            r = {s, 1'b0, e, {GUARD_W{1'b0}}, 1'b1, m};
        end
        return r;
    endfunction

    logic                 a_s, b_s_eff;
    logic [EXP_W-1:0]     a_e, b_e;
    logic [MAN_W-1:0]     a_m, b_m;
    logic                 a_is_x;
    logic                 a_nan, b_nan, a_inf, b_inf;
    logic                 nan_c, inf_c, inf_s_c;
    logic [UNP_W-1:0]     a_unp, b_unp, x_unp, y_unp;
    logic [DIFF_W-1:0]    diff_c;
    logic [PAY_W-1:0]     pay_in;

    // Effective sign, magnitude ordering, unpack and special classification
    always_comb begin
        a_s     = in_a[W-1];
        b_s_eff = in_b[W-1] ^ in_sub;
        a_e     = in_a[W-2 -: EXP_W];
        b_e     = in_b[W-2 -: EXP_W];
        a_m     = in_a[MAN_W-1:0];
        b_m     = in_b[MAN_W-1:0];
        a_is_x  = (in_a[W-2:0] >= in_b[W-2:0]);
        a_unp   = unpack(a_s, a_e, a_m);
        b_unp   = unpack(b_s_eff, b_e, b_m);
        x_unp   = a_is_x ? a_unp : b_unp;
        y_unp   = a_is_x ? b_unp : a_unp;
        diff_c  = x_unp[UNP_W-2 -: DIFF_W] - y_unp[UNP_W-2 -: DIFF_W];

        a_nan   = (&a_e) && (a_m != '0);
        b_nan   = (&b_e) && (b_m != '0);
        a_inf   = (&a_e) && (a_m == '0);
        b_inf   = (&b_e) && (b_m == '0);
        nan_c   = a_nan || b_nan || (a_inf && b_inf && (a_s != b_s_eff));
        inf_c   = !nan_c && (a_inf || b_inf);
        inf_s_c = inf_c && (a_inf ? a_s : b_s_eff);

        pay_in  = {x_unp, y_unp, diff_c, nan_c, inf_c, inf_s_c, in_tag};
    end

    logic             main_vld_q, main_vld_d;
    logic [PAY_W-1:0] main_pay_q, main_pay_d;
    logic             accept, main_free;

    assign accept    = in_valid && in_ready;
    assign main_free = !main_vld_q || out_ready;

`ifdef FAS_SKID_EN
    logic             skid_vld_q, skid_vld_d;
    logic [PAY_W-1:0] skid_pay_q, skid_pay_d;

    // Skid entry empty is the only readiness condition; never depends on out_ready
    assign in_ready = !skid_vld_q && !rst;

    always_comb begin
        main_vld_d = main_vld_q;
        main_pay_d = main_pay_q;
        skid_vld_d = skid_vld_q;
        skid_pay_d = skid_pay_q;
        if (main_free) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_pay_d = skid_pay_q;
                skid_vld_d = 1'b0;
            end else begin
                main_vld_d = accept;
                if (accept) begin
                    main_pay_d = pay_in;
                end
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_pay_d = pay_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_pay_q <= '0;
            skid_vld_q <= 1'b0;
            skid_pay_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_pay_q <= main_pay_d;
            skid_vld_q <= skid_vld_d;
            skid_pay_q <= skid_pay_d;
        end
    end
`else
    assign in_ready = main_free && !rst;

    always_comb begin
        main_vld_d = main_vld_q;
        main_pay_d = main_pay_q;
        if (main_free) begin
            main_vld_d = accept;
            if (accept) begin
                main_pay_d = pay_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_pay_q <= '0;
        end else begin
            main_vld_q <= main_vld_d;
            main_pay_q <= main_pay_d;
        end
    end
`endif

    assign out_valid = main_vld_q;
    assign {out_x, out_y, out_diff, out_nan, out_inf, out_inf_s, out_tag} = main_pay_q;

endmodule

// File: tb/tb_fas_unpack_stage.sv
// Self-checking bench for fas_unpack_stage with a queue-based reference model.
module tb_fas_unpack_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sub, out_valid, out_ready;
    logic        out_nan, out_inf, out_inf_s;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_tag, out_tag;
    logic [41:0] out_x, out_y;
    logic [8:0]  out_diff;

    always #5 clk = ~clk;

    fas_unpack_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sub(in_sub), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x), .out_y(out_y),
        .out_diff(out_diff), .out_nan(out_nan), .out_inf(out_inf),
        .out_inf_s(out_inf_s), .out_tag(out_tag)
    );

    typedef struct {
        logic [41:0] x;
        logic [41:0] y;
        logic [8:0]  diff;
        logic        nan;
        logic        inf;
        logic        inf_s;
        logic [3:0]  tag;
    } exp_t;

    exp_t         q[$];
    int           errors = 0;
    int           checks = 0;
    int           npop = 0;
    bit           accepted = 0;
    bit           prev_stall = 0;
    logic [99:0]  snap;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, got, expv);
        end
    endtask

    function automatic logic [41:0] mk(input logic s, input int unsigned e, input int unsigned sig);
        return {s, 9'(e), 32'(sig)};
    endfunction

    // Float-level view: order by magnitude, flush tiny exponents, classify specials
    function automatic logic [41:0] flush(input bit s, input int unsigned mag);
        int unsigned e;
        e = mag / (1 << 23);
        if (e == 0) return 42'd0;
        return mk(s, e, (1 << 23) + (mag % (1 << 23)));
    endfunction

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic sub, input logic [3:0] tag);
        exp_t        r;
        int unsigned mag_a, mag_b, mx, my, ex, ey;
        bit          sa, sb, sx, sy, nan_a, nan_b, inf_a, inf_b;
        mag_a = a & 32'h7FFF_FFFF;
        mag_b = b & 32'h7FFF_FFFF;
        sa = a[31];
        sb = b[31] ^ sub;
        if (mag_a >= mag_b) begin mx = mag_a; sx = sa; my = mag_b; sy = sb; end
        else                begin mx = mag_b; sx = sb; my = mag_a; sy = sa; end
        ex = mx / (1 << 23);
        ey = my / (1 << 23);
        r.x    = flush(sx, mx);
        r.y    = flush(sy, my);
        r.diff = 9'(ex - ey);
        nan_a = (mag_a / (1 << 23) == 255) && (mag_a % (1 << 23) != 0);
        nan_b = (mag_b / (1 << 23) == 255) && (mag_b % (1 << 23) != 0);
        inf_a = (mag_a == 32'h7F80_0000);
        inf_b = (mag_b == 32'h7F80_0000);
        r.nan   = nan_a || nan_b || (inf_a && inf_b && (sa != sb));
        r.inf   = !r.nan && (inf_a || inf_b);
        r.inf_s = r.inf ? (inf_a ? sa : sb) : 1'b0;
        r.tag   = tag;
        return r;
    endfunction

    // One clock: observe at negedge, scoreboard, then advance to posedge+1
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (prev_stall)
            chk("stable", {out_x, out_y, out_diff, out_nan, out_inf, out_inf_s, out_tag}, snap);
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 1'b0);
            else begin
                e = q.pop_front();
                npop++;
                chk("x", out_x, e.x);
                chk("y", out_y, e.y);
                chk("diff", out_diff, e.diff);
                chk("flags", {out_nan, out_inf, out_inf_s}, {e.nan, e.inf, e.inf_s});
                chk("tag", out_tag, e.tag);
            end
        end
        accepted = in_valid && in_ready;
        if (accepted) q.push_back(model(in_a, in_b, in_sub, in_tag));
        prev_stall = out_valid && !out_ready && !rst;
        snap = {out_x, out_y, out_diff, out_nan, out_inf, out_inf_s, out_tag};
        if (rst) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [3:0] tag);
        in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 50 && !accepted; i++) tick();
        in_valid = 1'b0;
        chk("accept", accepted, 1'b1);
    endtask

    // Stalled output: check against literals, then consume through the scoreboard
    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic [3:0] tag, input exp_t e);
        out_ready = 1'b0;
        send(a, b, sub, tag);
        chk({name, "_valid"}, out_valid, 1'b1);
        chk({name, "_x"}, out_x, e.x);
        chk({name, "_y"}, out_y, e.y);
        chk({name, "_diff"}, out_diff, e.diff);
        chk({name, "_flags"}, {out_nan, out_inf, out_inf_s}, {e.nan, e.inf, e.inf_s});
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    function automatic logic [31:0] rnd_op();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 5))
            0: v = {v[31], 8'hFF, 23'd0};
            1: v = {v[31], 8'hFF, v[22:0] | 23'd1};
            2: v = {v[31], 8'h00, v[22:0]};
            default: v = {v[31], 8'($urandom_range(1, 254)), v[22:0]};
        endcase
        return v;
    endfunction

    initial begin
        int          sent, cyc;
        logic [31:0] ra, rb;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_sub = 1'b0; in_tag = '0;
        tick();
        tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outputs", {out_x, out_y, out_diff, out_nan, out_inf, out_inf_s, out_tag}, 100'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        directed("add", 32'h3F80_0000, 32'h4000_0000, 1'b0, 4'd1,
                 '{x: mk(0, 'h80, 'h0080_0000), y: mk(0, 'h7F, 'h0080_0000), diff: 9'd1,
                   nan: 0, inf: 0, inf_s: 0, tag: 4'd1});
        directed("sub", 32'h3F80_0000, 32'h4040_0000, 1'b1, 4'd2,
                 '{x: mk(1, 'h80, 'h00C0_0000), y: mk(0, 'h7F, 'h0080_0000), diff: 9'd1,
                   nan: 0, inf: 0, inf_s: 0, tag: 4'd2});
        directed("tie", 32'h40A0_0000, 32'h40A0_0000, 1'b1, 4'd3,
                 '{x: mk(0, 'h81, 'h00A0_0000), y: mk(1, 'h81, 'h00A0_0000), diff: 9'd0,
                   nan: 0, inf: 0, inf_s: 0, tag: 4'd3});
        directed("nan_in", 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 4'd4,
                 '{x: mk(0, 'hFF, 'h00C0_0000), y: mk(0, 'h7F, 'h0080_0000), diff: 9'h80,
                   nan: 1, inf: 0, inf_s: 0, tag: 4'd4});
        directed("inf_sub_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1, 4'd5,
                 '{x: mk(0, 'hFF, 'h0080_0000), y: mk(1, 'hFF, 'h0080_0000), diff: 9'd0,
                   nan: 1, inf: 0, inf_s: 0, tag: 4'd5});
        directed("inf_add_ninf", 32'h7F80_0000, 32'hFF80_0000, 1'b0, 4'd6,
                 '{x: mk(0, 'hFF, 'h0080_0000), y: mk(1, 'hFF, 'h0080_0000), diff: 9'd0,
                   nan: 1, inf: 0, inf_s: 0, tag: 4'd6});
        directed("ninf", 32'hFF80_0000, 32'h3F80_0000, 1'b0, 4'd7,
                 '{x: mk(1, 'hFF, 'h0080_0000), y: mk(0, 'h7F, 'h0080_0000), diff: 9'h80,
                   nan: 0, inf: 1, inf_s: 1, tag: 4'd7});
        directed("ftz", 32'h0000_0001, 32'h8000_0000, 1'b0, 4'd8,
                 '{x: 42'd0, y: 42'd0, diff: 9'd0, nan: 0, inf: 0, inf_s: 0, tag: 4'd8});

        // Back-to-back throughput with the output always ready
        out_ready = 1'b1;
        sent = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_a = rnd_op(); in_b = rnd_op(); in_sub = 1'($urandom); in_tag = 4'(i);
            tick();
            if (accepted) sent++;
        end
        in_valid = 1'b0;
        chk("throughput", sent, 8);
        tick();
        chk("tp_drained", q.size(), 0);

        // Random backpressure stream, tags 0..7
        npop = 0;
        sent = 0;
        ra = rnd_op(); rb = ($urandom_range(0, 3) == 0) ? ra : rnd_op();
        for (cyc = 0; cyc < 400 && (sent < 8 || q.size() != 0); cyc++) begin
            in_valid  = (sent < 8) && ($urandom_range(0, 3) != 0);
            in_a = ra; in_b = rb; in_sub = 1'($urandom); in_tag = 4'(sent);
            out_ready = 1'($urandom);
            tick();
            if (accepted) begin
                sent++;
                ra = rnd_op(); rb = ($urandom_range(0, 3) == 0) ? ra : rnd_op();
            end
        end
        in_valid = 1'b0;
        chk("bp_count", npop, 8);
        chk("bp_drained", q.size(), 0);

        // Reset with pairs held, then resume
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 32'h4000_0000; in_b = 32'h3F80_0000; in_sub = 1'b0; in_tag = 4'd10;
        tick();
        in_tag = 4'd11;
        tick();
        in_valid = 1'b0;
        chk("held_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_outputs", {out_x, out_y, out_diff, out_nan, out_inf, out_inf_s, out_tag}, 100'd0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        send(32'h4040_0000, 32'h3F80_0000, 1'b1, 4'd12);
        chk("resume_tag", out_tag, 4'd12);
        tick();
        chk("resume_drained", q.size(), 0);
        chk("resume_idle", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fas_unpack_stage.md
# fas_unpack_stage

Parametrised operand-unpack and ordering stage at the head of the floating-point add/subtract pipeline. It accepts two IEEE-754-style operands and an add/sub opcode over a valid/ready handshake, applies the effective sign for subtract, and orders the operands so X has the larger magnitude. It unpacks both to sign/exponent/significand, flushes denormals to zero, classifies NaN/Inf, and precomputes the alignment shift. It feeds the align/add stages and supports downstream backpressure.

## Interface
- EXP_W, 8, exponent field width
- MAN_W, 23, stored mantissa width
- GUARD_W, 8, zero headroom bits above the hidden bit; SIG_W = GUARD_W+1+MAN_W (default 32)
- TAG_W, 4, sideband tag width, passed through unchanged
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  operand pair present
- in_ready  output  1  stage can accept this cycle
- in_sub  input  1  0 = add, 1 = subtract (a − b)
- in_a, in_b  input  1+EXP_W+MAN_W  packed operands {s, e, m}
- in_tag  input  TAG_W  sideband
- out_valid  output  1  output holds an unpacked pair
- out_ready  input  1  downstream accepts
- out_x, out_y  output  1+(EXP_W+1)+SIG_W  {s, 0‖e, 0^GUARD_W‖hidden‖m}, default 42 bits
- out_diff  output  EXP_W+1  x exponent − y exponent, always ≥ 0
- out_nan, out_inf  output  1  special-result flags
- out_inf_s  output  1  sign of the infinite result when out_inf=1
- out_tag  output  TAG_W  tag of the pair on out_x/out_y

## Operation
- A transfer occurs when in_valid && in_ready. Output is consumed when out_valid && out_ready.
- Effective b sign: b.s ^ in_sub. a's sign is never altered.
- Magnitude compare uses the raw bits [W−2:0] (unsigned).
  - If |a| ≥ |b|: X = a, Y = b(effective). Ties select a as X.
  - Otherwise: X = b(effective), Y = a.
- Unpack: an operand with e == 0 (zero or denormal) becomes all-zero: s=0, e=0, sig=0. All other operands produce sig = {GUARD_W zeros, 1, m} and exp = {0, e}. This includes Inf/NaN, whose values downstream ignores.
- out_diff = X.exp − Y.exp, computed after flushing.
- Classification uses the unflushed fields:
  - NaN: e all-ones, m ≠ 0. Inf: e all-ones, m == 0.
  - out_nan = 1 if either operand is NaN, or if both are Inf and their effective signs differ.
  - out_inf = 1 if out_nan = 0 and at least one operand is Inf.
  - out_inf_s = effective sign of the Inf operand. When both are Inf, their signs are equal and that sign is used.
  - out_inf_s = 0 when out_inf = 0.
- Ordering is preserved. Every accepted pair appears exactly once on the outputs.
- Reset mid-operation discards all held pairs, including the skid entry.

## Timing
- Latency: 1 cycle. A pair accepted on edge N is visible with out_valid=1 after edge N.
- Throughput: 1 pair/cycle while out_ready=1.
- Output stability: while out_valid && !out_ready, all out_* signals hold stable.
- Reset values: out_valid=0; out_x, out_y, out_diff, out_tag, and all flags = 0. in_ready=0 during rst and 1 on the first cycle after rst is released.
- Simultaneous accept and consume on the same edge: the main register loads the new pair with no bubble.
- in_valid with in_ready=0: no transfer occurs, and the inputs are ignored.

## Configuration
- FAS_SKID_EN defined: a 2-entry skid buffer is used.
  - in_ready is a register output and equals "skid entry empty". There is no combinational path from out_ready.
  - A pair accepted while the output is stalled goes into the skid entry.
  - When the output drains, the skid entry moves to the main register.
  - Full throughput is sustained under any out_ready pattern.
- FAS_SKID_EN undefined: a single output register is used, and in_ready = !out_valid || out_ready (combinational).
- Datapath results are identical in both builds. Only in_ready timing and buffering differ.

## Test plan
- Add 0x3F800000 + 0x40000000 → out_x={0,0x080,0x00800000}, out_y={0,0x07F,0x00800000}, out_diff=1, all flags 0.
- Subtract 0x3F800000 − 0x40400000 → out_x={1,0x080,0x00C00000}, out_y={0,0x07F,0x00800000}, out_diff=1. Tie check: subtract 5.0 − 5.0 → out_x=a with s=0, out_y s=1, out_diff=0.
- Specials:
  - 0x7FC00000 + 0x3F800000 → out_nan=1.
  - 0x7F800000 − 0x7F800000 → out_nan=1.
  - 0x7F800000 + 0xFF800000 → out_nan=1.
  - 0xFF800000 + 0x3F800000 → out_inf=1, out_inf_s=1.
- FTZ: 0x00000001 + 0x80000000 → out_x=0, out_y=0, out_diff=0, flags 0.
- Backpressure: stream 8 tagged pairs (tags 0–7) with out_ready toggling randomly → all 8 emerge in order, none lost or duplicated, outputs stable while stalled. With FAS_SKID_EN, in_ready never depends combinationally on out_ready.
- Reset mid-stream: assert rst for 1 cycle with 2 pairs held → next cycle out_valid=0 and all outputs 0. Resumed traffic then starts with tag of the first post-reset pair.
